plru_way_allocator: RTL
=======================

# plru_way_allocator

Replacement controller for the set-associative L1 caches and the branch target buffer. It holds one tree pseudo-LRU state per set, updates it on every hit (touch), and serves miss allocations through a request / victim / commit handshake. Victim choice prefers an invalid way; otherwise it uses the PLRU tree. It sits between the cache control FSM and the tag/data arrays.

## Interface
- S_IDX, default 4: set index width; NUM_SETS = 2**S_IDX.
- W_IDX, default 2: way index width; WAYS = 2**W_IDX; tree has WAYS-1 node bits per set.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high.
- touch_valid  in  1  hit access this cycle.
- touch_set  in  S_IDX  set of hit.
- touch_way  in  W_IDX  way of hit.
- alloc_req  in  1  miss needs a victim.
- alloc_set  in  S_IDX  set of miss.
- alloc_vmask  in  WAYS  per-way valid bits of that set; bit i=1 means way i holds valid data.
- alloc_ready  out  1  allocator can accept alloc_req.
- victim_valid  out  1  victim_way is valid and held.
- victim_way  out  W_IDX  chosen way.
- alloc_done  in  1  fill of victim complete; commits the allocation.
- busy  out  1  allocation in flight (state != IDLE).

## Operation
- Tree encoding is heap-indexed: root is node 1; node n has children 2n and 2n+1; leaf ways are ordered left to right.
- Victim walk starts at the root: bit 0 goes left, bit 1 goes right.
- Update on access to way w: each node on w's path is set to point away from w. The bit is 1 if w is in the left subtree, 0 if w is in the right subtree.
- Victim selection:
  - If alloc_vmask != all-ones, the victim is the lowest-index way with vmask bit 0.
  - Otherwise the victim is the tree victim.
- FSM has three states:
  - IDLE: alloc_ready=1. alloc_req=1 captures alloc_set and alloc_vmask, then goes to PICK.
  - PICK: computes the victim from the current tree of the captured set, including any touch update committed at this same edge. Registers victim_way, then goes to WAIT.
  - WAIT: victim_valid=1 and victim_way is held stable. alloc_done=1 applies the update for (captured set, victim_way), then goes to IDLE.
- Touches are accepted in every state, one per cycle, with no stall.
- Touches never alter a victim already registered in WAIT.
- alloc_done outside WAIT is ignored. alloc_req outside IDLE is ignored; the requester holds it until alloc_ready.
- Same-edge touch and commit:
  - Both are applied, touch first, then commit.
  - For the same set, node bits on the commit path take the commit value.
  - Different sets update independently.
- Reset clears every tree bit to 0 and forces IDLE. A reset during PICK or WAIT abandons the allocation with no tree update.

## Timing
- Reset values: alloc_ready=1, victim_valid=0, victim_way=0, busy=0, all tree bits 0.
- Latency: with alloc_req accepted at edge E0, state is PICK in the next cycle, and victim_valid rises after E1 (2 edges from acceptance).
- Commit: alloc_done sampled high in WAIT at edge Ec updates the tree at Ec. After Ec, victim_valid=0 and alloc_ready=1.
- Back-to-back allocation: the minimum interval is 3 cycles (IDLE, PICK, WAIT with immediate alloc_done).
- A touch at edge E is visible to any victim computed in PICK at or after E.

## Structure
- Shared package plru_pkg holds:
  - constants S_IDX, W_IDX and the derived WAYS and NODES;
  - typedef plru_tree_t (logic [WAYS-1:1]);
  - state enum alloc_state_e {IDLE, PICK, WAIT};
  - functions plru_victim(tree) and plru_update(tree, way), shared with the testbench model.
- Sub-module plru_set_array: NUM_SETS tree registers.
  - Two update ports (touch, commit) with commit-after-touch ordering.
  - One combinational read port.
  - Synchronous reset.
- The top level contains the FSM, the capture registers and the invalid-way priority encoder.

## Test plan
- Reset, then alloc set 3 with vmask 4'b1111 -> victim_way 0 two edges after acceptance; commit with alloc_done.
- Repeating alloc/commit on set 3 with full vmask -> victims 0, 2, 1, 3 in order; set 5 is unaffected (its victim is still 0).
- alloc set 7 with vmask 4'b1011 -> victim 2 regardless of tree. With vmask 4'b1110 -> victim 0.
- Set 3 reset state, touch way 0 and commit way 2 on the same edge -> next victim for set 3 is way 1.
- Touch different ways of the captured set during WAIT -> victim_way held unchanged. rst during WAIT -> victim_valid=0, alloc_ready=1 next cycle, set tree all zeros.
- 1000 random cycles of touches, allocs and random-delay alloc_done -> victim_way matches the plru_pkg function model on every victim_valid cycle.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared sizing, types and tree pseudo-LRU helpers for the way allocator and its models.
// Heap-indexed tree: node 1 is the root and node n has children 2n and 2n+1.
package plru_pkg;

  localparam int unsigned S_IDX    = 4;
  localparam int unsigned W_IDX    = 2;
  localparam int unsigned NUM_SETS = 1 << S_IDX;
  localparam int unsigned WAYS     = 1 << W_IDX;
  localparam int unsigned NODES    = WAYS - 1;

  typedef logic [WAYS-1:1] plru_tree_t;

  typedef enum logic [1:0] {IDLE, PICK, WAIT} alloc_state_e;

  // Walk from the root: a 0 bit goes left, a 1 bit goes right.
  function automatic logic [W_IDX-1:0] plru_victim(input plru_tree_t tree);
    int unsigned node;
    node = 1;
    for (int l = 0; l < int'(W_IDX); l++) begin
      node = (node << 1) | 32'(tree[node]);
    end
    return W_IDX'(node - WAYS);
  endfunction

  // Every node on the way's path is pointed away from that way.
  function automatic plru_tree_t plru_update(input plru_tree_t tree,
                                             input logic [W_IDX-1:0] way);
    plru_tree_t  t;
    int unsigned node;
    logic        b;
    t    = tree;
    node = 1;
    for (int l = 0; l < int'(W_IDX); l++) begin
      b       = way[W_IDX-1-l];
      t[node] = ~b;
      node    = (node << 1) | 32'(b);
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_set_array.sv
// Per-set PLRU tree storage with a touch port and a commit port; commit wins over touch.
// The read port returns the next-state tree so a same-edge touch is visible to the reader.
module plru_set_array import plru_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_valid,
  input  logic [S_IDX-1:0] touch_set,
  input  logic [W_IDX-1:0] touch_way,
  input  logic             commit_valid,
  input  logic [S_IDX-1:0] commit_set,
  input  logic [W_IDX-1:0] commit_way,
  input  logic [S_IDX-1:0] rd_set,
  output plru_tree_t       rd_tree
);

  plru_tree_t tree_q [NUM_SETS];
  plru_tree_t tree_d [NUM_SETS];

  always_comb begin
    for (int s = 0; s < int'(NUM_SETS); s++) begin
      tree_d[s] = tree_q[s];
      if (touch_valid && (touch_set == S_IDX'(s))) begin
        tree_d[s] = plru_update(tree_d[s], touch_way);
      end
      // Applied after the touch so commit-path nodes take the commit value.
      if (commit_valid && (commit_set == S_IDX'(s))) begin
        tree_d[s] = plru_update(tree_d[s], commit_way);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < int'(NUM_SETS); s++) begin
      if (rst) begin
        tree_q[s] <= '0;
      end else begin
        tree_q[s] <= tree_d[s];
      end
    end
  end

  assign rd_tree = tree_d[rd_set];

endmodule

// File: rtl/plru_way_allocator.sv
// Miss-allocation controller: request / victim / commit handshake over per-set PLRU trees.
// An invalid way always wins over the tree victim.
module plru_way_allocator import plru_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_valid,
  input  logic [S_IDX-1:0] touch_set,
  input  logic [W_IDX-1:0] touch_way,
  input  logic             alloc_req,
  input  logic [S_IDX-1:0] alloc_set,
  input  logic [WAYS-1:0]  alloc_vmask,
  output logic             alloc_ready,
  output logic             victim_valid,
  output logic [W_IDX-1:0] victim_way,
  input  logic             alloc_done,
  output logic             busy
);

  alloc_state_e     state;
  logic [S_IDX-1:0] cap_set;
  logic [WAYS-1:0]  cap_vmask;
  plru_tree_t       cap_tree;
  logic             commit_valid;
  logic [W_IDX-1:0] inv_way;
  logic [W_IDX-1:0] pick_way;

  assign commit_valid = (state == WAIT) && alloc_done;

  plru_set_array u_sets (
    .clk          (clk),
    .rst          (rst),
    .touch_valid  (touch_valid),
    .touch_set    (touch_set),
    .touch_way    (touch_way),
    .commit_valid (commit_valid),
    .commit_set   (cap_set),
    .commit_way   (victim_way),
    .rd_set       (cap_set),
    .rd_tree      (cap_tree)
  );

  always_comb begin
    inv_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!cap_vmask[i]) begin
        inv_way = W_IDX'(i);
      end
    end
  end

  assign pick_way = (&cap_vmask) ? plru_victim(cap_tree) : inv_way;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      alloc_ready  <= 1'b1;
      victim_valid <= 1'b0;
      victim_way   <= '0;
      busy         <= 1'b0;
      cap_set      <= '0;
      cap_vmask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (alloc_req) begin
            cap_set     <= alloc_set;
            cap_vmask   <= alloc_vmask;
            alloc_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= PICK;
          end
        end
        PICK: begin
          victim_way   <= pick_way;
          victim_valid <= 1'b1;
          state        <= WAIT;
        end
        WAIT: begin
          if (alloc_done) begin
            victim_valid <= 1'b0;
            alloc_ready  <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
